fwd_hazard_unit: RTL

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use hazard detection for an in-order pipeline decode stage.
// Latency: fwd_sel/stall are combinational from decode inputs and tracked slots; slots update each edge.
// Backpressure: stall holds fetch/decode for one cycle on a load-use; flush squashes decode instead.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   id_valid          instruction present in decode
//   id_src            NSRC source addresses, operand s at [s*AW +: AW]
//   id_src_used       per-operand read enable
//   id_dst            destination register of the decode instruction
//   id_regwrite       decode instruction writes a register
//   id_memtoreg       decode instruction is a load
//   flush             squash the decode instruction this cycle
//   fwd_sel           per-operand source: 0 = register file, k = slot k-1
//   stall             load-use stall request
//   stall_cnt         saturating count of stall cycles
module fwd_hazard_unit #(
    parameter int AW       = 4,
    parameter int NSRC     = 2,
    parameter int DEPTH    = 2,
    parameter int ZERO_REG = 1,
    localparam int SW      = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic [AW-1:0]        id_dst,
    input  logic                 id_regwrite,
    input  logic                 id_memtoreg,
    input  logic                 flush,
    output logic [NSRC*SW-1:0]   fwd_sel,
    output logic                 stall,
    output logic [15:0]          stall_cnt
);

    typedef struct packed {
        logic          vld;
        logic          rw;
        logic          mem;
        logic [AW-1:0] dst;
    } slot_t;

    // slots[0] is the youngest writer (EX), slots[DEPTH-1] the oldest tracked.
    slot_t slots [DEPTH];

    logic          load_use;
    logic [AW-1:0] src_s;
    logic [SW-1:0] sel_s;

    always_comb begin
        fwd_sel  = '0;
        load_use = 1'b0;
        src_s    = '0;
        sel_s    = '0;
        for (int s = 0; s < NSRC; s++) begin
            src_s = id_src[s*AW +: AW];
            sel_s = '0;
            // Walk from oldest to youngest so the youngest matching writer
            // is the last assignment and therefore wins.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (slots[k].vld && slots[k].rw && (slots[k].dst == src_s) &&
                    id_src_used[s] && !((ZERO_REG != 0) && (src_s == '0))) begin
                    sel_s = SW'(k + 1);
                end
            end
            if (id_valid) begin
                fwd_sel[s*SW +: SW] = sel_s;
                // Only a load still in EX cannot forward; one cycle later it can.
                if ((sel_s == SW'(1)) && slots[0].mem) begin
                    load_use = 1'b1;
                end
            end
        end
        stall = id_valid && !flush && load_use;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                slots[i] <= slots[i-1];
            end
            // A stalled or flushed decode instruction must not appear as a
            // writer; it re-enters (or vanishes) on a later cycle.
            if (id_valid && !stall && !flush) begin
                slots[0] <= '{vld: 1'b1, rw: id_regwrite, mem: id_memtoreg, dst: id_dst};
            end else begin
                slots[0] <= '0;
            end
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule
